// File: rtl/regfile_write_sched.sv
// Owns the register file write port and bank-select strobe: round-robin two writers, sequence bank switches.
// Latency: grant -> rf_write next cycle; bank accept -> strobe 2 cycles later, cur_bank 3 later. Backpressure: ready is combinational grant; banked writes stall during a switch.
module regfile_write_sched #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 4,
    parameter int BANK_W      = 2,
    parameter int SCHWAP_BASE = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              bank_valid,
    input  logic [BANK_W-1:0] bank_sel,
    output logic              bank_ready,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_writeAddr,
    output logic [DATA_W-1:0] rf_writeData,
    output logic [BANK_W-1:0] rf_schwapReg,
    output logic              rf_schwapClk,
    output logic [BANK_W-1:0] cur_bank
);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    localparam logic [ADDR_W-1:0] BankedBase = ADDR_W'(SCHWAP_BASE);

    state_t            state;
    logic [BANK_W-1:0] target;
    logic              rrPtr;
    logic              inIdle;
    logic              switchReq;
    logic              fence;
    logic              elig0;
    logic              elig1;
    logic              grant0;
    logic              grant1;

    assign inIdle     = (state == IDLE);
    assign bank_ready = inIdle && bank_valid;
    assign switchReq  = bank_ready && (bank_sel != cur_bank);
    // The accept cycle itself is fenced so a banked write cannot race the new strobe.
    assign fence      = !inIdle || switchReq;

    assign elig0  = req0_valid && ((req0_addr < BankedBase) || !fence);
    assign elig1  = req1_valid && ((req1_addr < BankedBase) || !fence);
    assign grant0 = elig0 && (!elig1 || !rrPtr);
    assign grant1 = elig1 && (!elig0 || rrPtr);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= SETUP;
            target       <= '0;
            rrPtr        <= 1'b0;
            rf_write     <= 1'b0;
            rf_writeAddr <= '0;
            rf_writeData <= '0;
            rf_schwapReg <= '0;
            rf_schwapClk <= 1'b0;
            cur_bank     <= '0;
        end else begin
            rf_write <= grant0 || grant1;
            if (grant0) begin
                rf_writeAddr <= req0_addr;
                rf_writeData <= req0_data;
                rrPtr        <= 1'b1;
            end else if (grant1) begin
                rf_writeAddr <= req1_addr;
                rf_writeData <= req1_data;
                rrPtr        <= 1'b0;
            end

            // Outputs are loaded on entry to the state they belong to.
            case (state)
                IDLE: begin
                    rf_schwapClk <= 1'b0;
                    if (switchReq) begin
                        target       <= bank_sel;
                        rf_schwapReg <= bank_sel;
                        state        <= SETUP;
                    end
                end
                SETUP: begin
                    rf_schwapClk <= 1'b1;
                    state        <= PULSE;
                end
                PULSE: begin
                    rf_schwapClk <= 1'b0;
                    cur_bank     <= target;
                    state        <= HOLD;
                end
                HOLD: begin
                    rf_schwapClk <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    rf_schwapClk <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed scenarios plus randomized traffic against a cycle-count reference model of regfile_write_sched.
module tb_regfile_write_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, bank_valid = 1'b0;
    logic [3:0]  req0_addr = '0, req1_addr = '0;
    logic [15:0] req0_data = '0, req1_data = '0;
    logic [1:0]  bank_sel = '0;
    logic        req0_ready, req1_ready, bank_ready;
    logic        rf_write, rf_schwapClk;
    logic [3:0]  rf_writeAddr;
    logic [15:0] rf_writeData;
    logic [1:0]  rf_schwapReg, cur_bank;

    int errors = 0;
    int checks = 0;

    regfile_write_sched #(.DATA_W(16), .ADDR_W(4), .BANK_W(2), .SCHWAP_BASE(12)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .bank_valid(bank_valid), .bank_sel(bank_sel), .bank_ready(bank_ready),
        .rf_write(rf_write), .rf_writeAddr(rf_writeAddr), .rf_writeData(rf_writeData),
        .rf_schwapReg(rf_schwapReg), .rf_schwapClk(rf_schwapClk), .cur_bank(cur_bank)
    );

    always #5 clk = ~clk;

    // Advance one cycle: through the rising edge, back to the falling edge where inputs are driven.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        #1;
        checks++; if (rf_write !== 1'b0) begin errors++; $display("FAIL rst_rf_write got=%b exp=0", rf_write); end
        checks++; if (rf_writeAddr !== 4'd0 || rf_writeData !== 16'd0) begin errors++; $display("FAIL rst_addr_data got=%0d/%h exp=0/0000", rf_writeAddr, rf_writeData); end
        checks++; if (cur_bank !== 2'd0 || rf_schwapClk !== 1'b0) begin errors++; $display("FAIL rst_bank_clk got=%0d/%b exp=0/0", cur_bank, rf_schwapClk); end
        @(negedge clk);
        reset = 1'b0;
        bank_valid = 1'b1;
        bank_sel = 2'd0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            checks++; if (rf_schwapClk !== (c == 2)) begin errors++; $display("FAIL init_strobe cyc=%0d got=%b exp=%b", c, rf_schwapClk, c == 2); end
            checks++; if (bank_ready !== (c == 4)) begin errors++; $display("FAIL init_bank_ready cyc=%0d got=%b exp=%b", c, bank_ready, c == 4); end
            checks++; if (rf_schwapReg !== 2'd0 || cur_bank !== 2'd0) begin errors++; $display("FAIL init_bank cyc=%0d got=%0d/%0d exp=0/0", c, rf_schwapReg, cur_bank); end
            tick();
        end
        bank_valid = 1'b0;
    endtask

    task automatic test_single_write;
        req0_valid = 1'b1; req0_addr = 4'd5; req0_data = 16'h1234;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready got=%b%b exp=10", req0_ready, req1_ready); end
        tick();
        req0_valid = 1'b0;
        #1;
        checks++; if (rf_write !== 1'b1 || rf_writeAddr !== 4'd5 || rf_writeData !== 16'h1234) begin
            errors++; $display("FAIL single_write got=%b %0d %h exp=1 5 1234", rf_write, rf_writeAddr, rf_writeData); end
        tick();
        #1;
        checks++; if (rf_write !== 1'b0 || rf_writeAddr !== 4'd5) begin errors++; $display("FAIL single_one_cycle got=%b %0d exp=0 5", rf_write, rf_writeAddr); end
    endtask

    task automatic test_alternate;
        // A lone req1 grant first leaves the pointer on req0.
        req1_valid = 1'b1; req1_addr = 4'd4; req1_data = 16'h5555;
        #1;
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL alt_prime got=%b exp=1", req1_ready); end
        tick();
        req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 16'hAAAA;
        for (int i = 0; i <= 4; i++) begin
            if (i == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            #1;
            if (i < 4) begin
                checks++; if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
                    errors++; $display("FAIL alt_grant i=%0d got=%b%b exp=%b%b", i, req0_ready, req1_ready, i % 2 == 0, i % 2 == 1); end
            end
            checks++; if (rf_write !== 1'b1) begin errors++; $display("FAIL alt_wr i=%0d got=%b exp=1", i, rf_write); end
            if (i > 0) begin
                checks++; if (rf_writeAddr !== ((i % 2 == 1) ? 4'd3 : 4'd4) || rf_writeData !== ((i % 2 == 1) ? 16'hAAAA : 16'h5555)) begin
                    errors++; $display("FAIL alt_data i=%0d got=%0d %h", i, rf_writeAddr, rf_writeData); end
            end
            tick();
        end
    endtask

    task automatic test_bank_switch;
        bank_valid = 1'b1; bank_sel = 2'd2;
        req0_valid = 1'b1; req0_addr = 4'd13; req0_data = 16'hB0B0;
        req1_valid = 1'b1; req1_addr = 4'd7;  req1_data = 16'h0707;
        #1;
        checks++; if (bank_ready !== 1'b1 || req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++; $display("FAIL sw_accept got=%b%b%b exp=110", bank_ready, req1_ready, req0_ready); end
        tick();
        bank_valid = 1'b0; req1_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) req0_valid = 1'b0;
            #1;
            if (k <= 4) begin
                checks++; if (req0_ready !== (k == 4)) begin errors++; $display("FAIL sw_fence T+%0d got=%b exp=%b", k, req0_ready, k == 4); end
                checks++; if (rf_schwapClk !== (k == 2) || rf_schwapReg !== 2'd2) begin
                    errors++; $display("FAIL sw_strobe T+%0d got=%b/%0d exp=%b/2", k, rf_schwapClk, rf_schwapReg, k == 2); end
                checks++; if (cur_bank !== ((k >= 3) ? 2'd2 : 2'd0)) begin errors++; $display("FAIL sw_cur T+%0d got=%0d", k, cur_bank); end
            end
            if (k == 1) begin
                checks++; if (rf_write !== 1'b1 || rf_writeAddr !== 4'd7) begin errors++; $display("FAIL sw_unbanked got=%b %0d exp=1 7", rf_write, rf_writeAddr); end
            end
            if (k == 5) begin
                checks++; if (rf_write !== 1'b1 || rf_writeAddr !== 4'd13 || rf_writeData !== 16'hB0B0) begin
                    errors++; $display("FAIL sw_banked got=%b %0d %h exp=1 13 b0b0", rf_write, rf_writeAddr, rf_writeData); end
            end
            tick();
        end
    endtask

    task automatic test_same_bank;
        bank_valid = 1'b1; bank_sel = 2'd2;
        req0_valid = 1'b1; req0_addr = 4'd14; req0_data = 16'hCAFE;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) req0_valid = 1'b0;
            #1;
            checks++; if (bank_ready !== 1'b1 || rf_schwapClk !== 1'b0 || cur_bank !== 2'd2) begin
                errors++; $display("FAIL same_bank k=%0d got=%b/%b/%0d exp=1/0/2", k, bank_ready, rf_schwapClk, cur_bank); end
            if (k == 0) begin
                checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL same_unfenced got=%b exp=1", req0_ready); end
            end
            tick();
        end
        bank_valid = 1'b0;
    endtask

    task automatic test_reset_mid_pulse;
        bank_valid = 1'b1; bank_sel = 2'd1;
        tick();
        bank_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 16'h0303;
        tick();
        req0_valid = 1'b0;
        #1;
        checks++; if (rf_schwapClk !== 1'b1 || rf_write !== 1'b1) begin errors++; $display("FAIL mid_pre got=%b/%b exp=1/1", rf_schwapClk, rf_write); end
        #1 reset = 1'b1;
        #1;
        checks++; if (rf_schwapClk !== 1'b0 || rf_write !== 1'b0) begin errors++; $display("FAIL mid_async got=%b/%b exp=0/0", rf_schwapClk, rf_write); end
        checks++; if (cur_bank !== 2'd0 || rf_schwapReg !== 2'd0) begin errors++; $display("FAIL mid_bank got=%0d/%0d exp=0/0", cur_bank, rf_schwapReg); end
        tick();
        reset = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            checks++; if (rf_schwapClk !== (c == 2)) begin errors++; $display("FAIL mid_restart cyc=%0d got=%b exp=%b", c, rf_schwapClk, c == 2); end
            tick();
        end
    endtask

    task automatic test_random;
        logic        p0v = 1'b0, p1v = 1'b0, bv = 1'b0;
        logic [3:0]  p0a = '0, p1a = '0;
        logic [15:0] p0d = '0, p1d = '0;
        logic [1:0]  bs = '0;
        logic        mWr = 1'b0, mPtr = 1'b0;
        logic [3:0]  mWa = '0;
        logic [15:0] mWd = '0;
        logic [1:0]  mSch = '0, mCur = '0, mTarget = '0;
        logic        inIdle, eB, sw, fence, e0, e1, g0, g1;
        int          swAt = -1;
        int          d;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        // Cycle i is counted from release; a switch accepted at cycle s occupies cycles s+1..s+3.
        for (int i = 0; i < 400; i++) begin
            if (!p0v) begin p0v = ($urandom % 3) != 0; p0a = 4'($urandom); p0d = 16'($urandom); end
            if (!p1v) begin p1v = ($urandom % 3) != 0; p1a = 4'($urandom); p1d = 16'($urandom); end
            if (!bv)  begin bv = ($urandom % 5) == 0; bs = 2'($urandom); end
            req0_valid = p0v; req0_addr = p0a; req0_data = p0d;
            req1_valid = p1v; req1_addr = p1a; req1_data = p1d;
            bank_valid = bv;  bank_sel = bs;
            #1;
            d = i - swAt;
            inIdle = !(d >= 1 && d <= 3);
            eB = inIdle && bv;
            sw = eB && (bs != mCur);
            fence = !inIdle || sw;
            e0 = p0v && (p0a < 4'd12 || !fence);
            e1 = p1v && (p1a < 4'd12 || !fence);
            g0 = e0 && (!e1 || !mPtr);
            g1 = e1 && (!e0 || mPtr);
            checks++; if (req0_ready !== g0 || req1_ready !== g1) begin errors++; $display("FAIL rnd_grant cyc=%0d got=%b%b exp=%b%b", i, req0_ready, req1_ready, g0, g1); end
            checks++; if (bank_ready !== eB) begin errors++; $display("FAIL rnd_bank_ready cyc=%0d got=%b exp=%b", i, bank_ready, eB); end
            checks++; if (rf_write !== mWr || rf_writeAddr !== mWa || rf_writeData !== mWd) begin
                errors++; $display("FAIL rnd_write cyc=%0d got=%b %0d %h exp=%b %0d %h", i, rf_write, rf_writeAddr, rf_writeData, mWr, mWa, mWd); end
            checks++; if (rf_schwapClk !== (d == 2) || rf_schwapReg !== mSch || cur_bank !== mCur) begin
                errors++; $display("FAIL rnd_bank cyc=%0d got=%b %0d %0d exp=%b %0d %0d", i, rf_schwapClk, rf_schwapReg, cur_bank, d == 2, mSch, mCur); end
            tick();
            if (g0) begin mWr = 1'b1; mWa = p0a; mWd = p0d; mPtr = 1'b1; p0v = 1'b0; end
            else if (g1) begin mWr = 1'b1; mWa = p1a; mWd = p1d; mPtr = 1'b0; p1v = 1'b0; end
            else mWr = 1'b0;
            if (d == 2) mCur = mTarget;
            if (sw) begin swAt = i; mTarget = bs; mSch = bs; end
            if (eB) bv = 1'b0;
        end
        req0_valid = 1'b0; req1_valid = 1'b0; bank_valid = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_single_write();
        test_alternate();
        test_bank_switch();
        test_same_bank();
        test_reset_mid_pulse();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
